// File: rtl/priv_trap_arbiter_1_13.sv
// -----------------------------------------------------------------------------
// priv_trap_arbiter_1_13
//
// Purpose
//   Collects interrupt requests into a pending register (mip image), decides
//   which trap (synchronous exception or interrupt) is taken, and hands it to
//   the pipeline through a three-state handshake: IDLE -> PEND -> COMMIT.
//   Exceptions always beat interrupts. Among exceptions the lowest index wins.
//   Among interrupts the highest index wins. Each trap is routed to M-mode or
//   S-mode from the delegation masks and the current privilege.
//
// Handshake
//   intr is high while a trap is selected (PEND) and during its commit cycle.
//   The pipeline accepts the trap by holding pipe_clear=1 with
//   ex_mem_stall=0 in a PEND cycle. The next cycle is COMMIT, where
//   trap_commit pulses for exactly one cycle. The cause fields are stable from
//   PEND entry through COMMIT. The only exception is an exception that arrives
//   while an interrupt is latched: it replaces the interrupt, and that counts
//   as a fresh PEND entry.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   int_set / int_clear      per-line raise / clear pulses (clear wins)
//   int_en, mideleg          per-line enable mask and S-mode delegation
//   ex_req, medeleg          exception requests and S-mode delegation
//   curr_priv                0=U, 1=S, 3=M
//   mstatus_mie/sie          global interrupt enables
//   pipe_clear, ex_mem_stall pipeline readiness to take the trap
//   epc                      pc of the faulting/interrupted instruction
//   mret, sret               trap return in progress (blocks interrupt pickup)
//   pending                  pending-interrupt register
//   intr, intr_to_s          trap selected / trap targets S-mode
//   trap_commit              one-cycle commit pulse
//   cause_int, cause_code    interrupt flag and source index
//   trap_epc                 epc captured at selection
//   dbg_state                FSM state (0=IDLE, 1=PEND, 2=COMMIT) for checkers
// -----------------------------------------------------------------------------
module priv_trap_arbiter_1_13 #(
   parameter int NUM_INT = 16,
   parameter int NUM_EX  = 16,
   parameter int CODE_W  = 5
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [NUM_INT-1:0] int_set,
   input  logic [NUM_INT-1:0] int_clear,
   input  logic [NUM_INT-1:0] int_en,
   input  logic [NUM_INT-1:0] mideleg,
   input  logic [NUM_EX-1:0]  ex_req,
   input  logic [NUM_EX-1:0]  medeleg,
   input  logic [1:0]         curr_priv,
   input  logic               mstatus_mie,
   input  logic               mstatus_sie,
   input  logic               pipe_clear,
   input  logic               ex_mem_stall,
   input  logic [31:0]        epc,
   input  logic               mret,
   input  logic               sret,
   output logic [NUM_INT-1:0] pending,
   output logic               intr,
   output logic               intr_to_s,
   output logic               trap_commit,
   output logic               cause_int,
   output logic [CODE_W-1:0]  cause_code,
   output logic [31:0]        trap_epc,
   output logic [1:0]         dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PEND   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   state_t              r_state;
   logic [NUM_INT-1:0]  r_pending;
   logic                r_cause_int;
   logic [CODE_W-1:0]   r_cause_code;
   logic                r_intr_to_s;
   logic [31:0]         r_trap_epc;

   // ---------------------------------------------------------------------
   // Combinational wires
   // ---------------------------------------------------------------------
   state_t              w_state_nxt;
   logic                w_load;       // capture a new cause this cycle
   logic                w_load_int;   // the capture is an interrupt
   logic                w_priv_not_m;
   logic                w_m_ok;       // M-targeted interrupts are enabled
   logic                w_s_ok;       // S-targeted interrupts are enabled
   logic [NUM_INT-1:0]  w_int_to_s;
   logic [NUM_INT-1:0]  w_takeable;
   logic                w_int_hit;
   logic [CODE_W-1:0]   w_int_code;
   logic                w_int_s;
   logic                w_ex_hit;
   logic [CODE_W-1:0]   w_ex_code;
   logic                w_ex_s;
   logic                w_ret_busy;
   logic [NUM_INT-1:0]  w_commit_clr;
   logic [NUM_INT-1:0]  w_pending_nxt;

   // ---------------------------------------------------------------------
   // Interrupt targeting and enables
   // ---------------------------------------------------------------------
   assign w_priv_not_m = (curr_priv != 2'd3);

   // M-targeted interrupts are always enabled below M-mode. In M-mode they
   // need MIE.
   assign w_m_ok = w_priv_not_m || mstatus_mie;

   // S-targeted interrupts are always enabled in U-mode. In S-mode they need
   // SIE. Delegation never targets S from M-mode, so no other case applies.
   assign w_s_ok = (curr_priv == 2'd0) || ((curr_priv == 2'd1) && mstatus_sie);

   assign w_int_to_s = mideleg & {NUM_INT{w_priv_not_m}};

   assign w_takeable = r_pending & int_en &
                       ((w_int_to_s  & {NUM_INT{w_s_ok}}) |
                        (~w_int_to_s & {NUM_INT{w_m_ok}}));

   assign w_ret_busy = mret || sret;

   // ---------------------------------------------------------------------
   // Priority encoders
   // ---------------------------------------------------------------------
   // Interrupts: walk upward so the highest takeable index is the last write.
   always_comb begin
      w_int_hit  = 1'b0;
      w_int_code = '0;
      w_int_s    = 1'b0;
      for (int i = 0; i < NUM_INT; i++) begin
         if (w_takeable[i]) begin
            w_int_hit  = 1'b1;
            w_int_code = CODE_W'(i);
            w_int_s    = w_int_to_s[i];
         end
      end
   end

   // Exceptions: walk downward so the lowest requesting index is the last write.
   always_comb begin
      w_ex_hit  = 1'b0;
      w_ex_code = '0;
      w_ex_s    = 1'b0;
      for (int i = NUM_EX - 1; i >= 0; i--) begin
         if (ex_req[i]) begin
            w_ex_hit  = 1'b1;
            w_ex_code = CODE_W'(i);
            w_ex_s    = medeleg[i] && w_priv_not_m;
         end
      end
   end

   // ---------------------------------------------------------------------
   // FSM next-state and capture control
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_load_int  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_ex_hit) begin
               w_load      = 1'b1;
               w_state_nxt = ST_PEND;
            end else if (w_int_hit && !w_ret_busy) begin
               w_load      = 1'b1;
               w_load_int  = 1'b1;
               w_state_nxt = ST_PEND;
            end
         end
         ST_PEND: begin
            // An exception replaces a latched interrupt. The state stays in
            // PEND for that cycle, so the replacement fields are shown for at
            // least one PEND cycle before commit and never change inside COMMIT.
            if (w_ex_hit && r_cause_int) begin
               w_load      = 1'b1;
               w_state_nxt = ST_PEND;
            end else if (pipe_clear && !ex_mem_stall) begin
               w_state_nxt = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            // Requests seen here are dropped. The pipeline presents them again.
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Pending register update
   // ---------------------------------------------------------------------
   // A committed interrupt retires its own pending bit, even if int_set raises
   // that bit in the same cycle.
   always_comb begin
      w_commit_clr = '0;
      if ((r_state == ST_COMMIT) && r_cause_int) begin
         for (int i = 0; i < NUM_INT; i++) begin
            if (CODE_W'(i) == r_cause_code) begin
               w_commit_clr[i] = 1'b1;
            end
         end
      end
   end

   assign w_pending_nxt = ((r_pending | int_set) & ~int_clear) & ~w_commit_clr;

   // ---------------------------------------------------------------------
   // Sequential state
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= ST_IDLE;
         r_pending    <= '0;
         r_cause_int  <= 1'b0;
         r_cause_code <= '0;
         r_intr_to_s  <= 1'b0;
         r_trap_epc   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_pending <= w_pending_nxt;
         if (w_load) begin
            r_cause_int  <= w_load_int;
            r_cause_code <= w_load_int ? w_int_code : w_ex_code;
            r_intr_to_s  <= w_load_int ? w_int_s : w_ex_s;
            r_trap_epc   <= epc;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign pending     = r_pending;
   assign intr        = (r_state == ST_PEND) || (r_state == ST_COMMIT);
   assign trap_commit = (r_state == ST_COMMIT);
   assign cause_int   = r_cause_int;
   assign cause_code  = r_cause_code;
   assign intr_to_s   = r_intr_to_s;
   assign trap_epc    = r_trap_epc;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_priv_trap_arbiter_1_13.sv
// -----------------------------------------------------------------------------
// Testbench for priv_trap_arbiter_1_13.
//
// The driver changes inputs on the falling edge. Before each rising edge it
// advances a behavioural reference model. When the model predicts a commit,
// the expected trap record is pushed into exp_q. A separate monitor samples
// the DUT 1ns after each rising edge. It pops and compares a record on every
// trap_commit, and it checks pending, intr and the latched fields against
// the model.
// -----------------------------------------------------------------------------
module tb_priv_trap_arbiter_1_13;

   localparam int NI    = 16;
   localparam int NE    = 16;
   localparam int CW    = 5;
   localparam int REC_W = 2 + CW + 32;  // {is_int, to_s, code, epc}

   // ------------------------------------------------------------------
   // Clock / reset and DUT signals
   // ------------------------------------------------------------------
   logic          CLK;
   logic          RST;
   logic [NI-1:0] int_set, int_clear, int_en, mideleg;
   logic [NE-1:0] ex_req, medeleg;
   logic [1:0]    curr_priv;
   logic          mstatus_mie, mstatus_sie, pipe_clear, ex_mem_stall;
   logic [31:0]   epc;
   logic          mret, sret;
   logic [NI-1:0] pending;
   logic          intr, intr_to_s, trap_commit, cause_int;
   logic [CW-1:0] cause_code;
   logic [31:0]   trap_epc;
   logic [1:0]    dbg_state;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   priv_trap_arbiter_1_13 #(.NUM_INT(NI), .NUM_EX(NE), .CODE_W(CW)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .int_set      (int_set),
      .int_clear    (int_clear),
      .int_en       (int_en),
      .mideleg      (mideleg),
      .ex_req       (ex_req),
      .medeleg      (medeleg),
      .curr_priv    (curr_priv),
      .mstatus_mie  (mstatus_mie),
      .mstatus_sie  (mstatus_sie),
      .pipe_clear   (pipe_clear),
      .ex_mem_stall (ex_mem_stall),
      .epc          (epc),
      .mret         (mret),
      .sret         (sret),
      .pending      (pending),
      .intr         (intr),
      .intr_to_s    (intr_to_s),
      .trap_commit  (trap_commit),
      .cause_int    (cause_int),
      .cause_code   (cause_code),
      .trap_epc     (trap_epc),
      .dbg_state    (dbg_state)
   );

   // ------------------------------------------------------------------
   // Scoreboard state
   // ------------------------------------------------------------------
   logic [REC_W-1:0] exp_q[$];
   int total = 0;
   int bad   = 0;
   int commit_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model
   // Model state describes the trap in flight:
   //   m_busy   - a trap has been chosen and not yet retired
   //   m_commit - the trap is in its commit cycle
   // ------------------------------------------------------------------
   logic [NI-1:0] m_pending = '0;
   bit            m_busy    = 0;
   bit            m_commit  = 0;
   bit            m_int     = 0;
   bit            m_to_s    = 0;
   int            m_code    = 0;
   logic [31:0]   m_epc     = '0;

   function automatic bit takeable(int i);
      bit to_s;
      if (!(m_pending[i] && int_en[i])) return 0;
      to_s = mideleg[i] && (curr_priv != 2'd3);
      if (to_s) return (curr_priv == 2'd0) || (curr_priv == 2'd1 && mstatus_sie);
      return (curr_priv != 2'd3) || mstatus_mie;
   endfunction

   function automatic logic [REC_W-1:0] pack(bit is_int, bit to_s, int code, logic [31:0] pc);
      return {is_int, to_s, CW'(code), pc};
   endfunction

   // Applies the rules for one rising edge, using the inputs driven now.
   task automatic model_update();
      int ex_idx;
      int int_idx;
      logic [NI-1:0] nxt;
      ex_idx  = -1;
      int_idx = -1;
      for (int c = 0; c < NE; c++)
         if (ex_req[c]) begin ex_idx = c; break; end
      for (int i = NI - 1; i >= 0; i--)
         if (takeable(i)) begin int_idx = i; break; end

      nxt = (m_pending | int_set) & ~int_clear;
      if (m_commit && m_int) nxt[m_code] = 1'b0;

      if (RST) begin
         m_pending = '0; m_busy = 0; m_commit = 0;
         m_int = 0; m_to_s = 0; m_code = 0; m_epc = '0;
         return;
      end
      m_pending = nxt;

      if (m_commit) begin
         // Trap retired; requests in this cycle are dropped.
         m_commit = 0;
         m_busy   = 0;
      end else if (!m_busy) begin
         if (ex_idx >= 0) begin
            m_busy = 1; m_int = 0; m_code = ex_idx;
            m_to_s = medeleg[ex_idx] && (curr_priv != 2'd3); m_epc = epc;
         end else if (int_idx >= 0 && !(mret || sret)) begin
            m_busy = 1; m_int = 1; m_code = int_idx;
            m_to_s = mideleg[int_idx] && (curr_priv != 2'd3); m_epc = epc;
         end
      end else begin
         if (ex_idx >= 0 && m_int) begin
            // An exception replaces the interrupt and waits at least one more cycle.
            m_int = 0; m_code = ex_idx;
            m_to_s = medeleg[ex_idx] && (curr_priv != 2'd3); m_epc = epc;
         end else if (pipe_clear && !ex_mem_stall) begin
            m_commit = 1;
            exp_q.push_back(pack(m_int, m_to_s, m_code, m_epc));
         end
      end
   endtask

   // ------------------------------------------------------------------
   // Driver
   // ------------------------------------------------------------------
   task automatic tick();
      model_update();
      @(negedge CLK);
      int_set   = '0;
      int_clear = '0;
      ex_req    = '0;
      mret      = 1'b0;
      sret      = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   // ------------------------------------------------------------------
   // Monitor
   // ------------------------------------------------------------------
   always @(posedge CLK) begin
      logic [REC_W-1:0] exp_rec;
      #1;
      chk("pending", 64'(pending), 64'(m_pending));
      chk("intr", 64'(intr), 64'(m_busy));
      if (intr)
         chk("held_fields", 64'({cause_int, intr_to_s, cause_code, trap_epc}),
             64'(pack(m_int, m_to_s, m_code, m_epc)));
      if (trap_commit) begin
         commit_cnt++;
         if (exp_q.size() == 0) begin
            chk("commit_unexpected", 64'(trap_commit), 64'(0));
         end else begin
            exp_rec = exp_q.pop_front();
            chk("commit_record", 64'({cause_int, intr_to_s, cause_code, trap_epc}),
                64'(exp_rec));
         end
      end else if (m_commit) begin
         chk("commit_missing", 64'(trap_commit), 64'(1));
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      int c0;
      RST = 1'b1;
      int_set = '0; int_clear = '0; int_en = '0; mideleg = '0;
      ex_req = '0; medeleg = '0; curr_priv = 2'd3;
      mstatus_mie = 1'b0; mstatus_sie = 1'b0;
      pipe_clear = 1'b0; ex_mem_stall = 1'b0;
      epc = '0; mret = 1'b0; sret = 1'b0;

      ticks(2);
      // Reset state
      chk("rst_pending", 64'(pending), 64'(0));
      chk("rst_intr", 64'(intr), 64'(0));
      chk("rst_intr_to_s", 64'(intr_to_s), 64'(0));
      chk("rst_trap_commit", 64'(trap_commit), 64'(0));
      chk("rst_cause_int", 64'(cause_int), 64'(0));
      chk("rst_cause_code", 64'(cause_code), 64'(0));
      chk("rst_trap_epc", 64'(trap_epc), 64'(0));
      RST = 1'b0;

      // M-mode interrupt 7, pipeline ready
      curr_priv = 2'd3; mstatus_mie = 1'b1; int_en = 16'h0080; pipe_clear = 1'b1;
      epc = 32'h0000_1000;
      int_set[7] = 1'b1;
      tick();
      chk("i7_pending", 64'(pending[7]), 64'(1));
      tick();
      chk("i7_pend_code", 64'(cause_code), 64'(7));
      tick();
      chk("i7_commit", 64'(trap_commit), 64'(1));
      chk("i7_cause_int", 64'(cause_int), 64'(1));
      chk("i7_to_s", 64'(intr_to_s), 64'(0));
      tick();
      chk("i7_cleared", 64'(pending[7]), 64'(0));
      ticks(2);

      // Interrupt 11 latched, then replaced by exception 2
      int_en = 16'h0800; pipe_clear = 1'b0; epc = 32'h0000_2000;
      int_set[11] = 1'b1;
      ticks(2);
      ex_req[2] = 1'b1; epc = 32'h8000_0010;
      ticks(2);
      int_en = '0; pipe_clear = 1'b1;
      ticks(3);
      chk("ex2_keeps_p11", 64'(pending[11]), 64'(1));
      int_clear[11] = 1'b1;
      ticks(2);

      // Exception delegation
      curr_priv = 2'd0; medeleg = 16'h0100; epc = 32'h0000_3000;
      ex_req[8] = 1'b1;
      ticks(4);
      curr_priv = 2'd3;
      ex_req[8] = 1'b1;
      ticks(4);

      // Clear beats set; lowest exception wins
      int_set[3] = 1'b1; int_clear[3] = 1'b1;
      tick();
      chk("set_clear_same", 64'(pending[3]), 64'(0));
      ex_req[5] = 1'b1; ex_req[1] = 1'b1; epc = 32'h0000_4000;
      tick();
      chk("ex_lowest", 64'(cause_code), 64'(1));
      ticks(3);

      // Long stall in PEND
      c0 = commit_cnt;
      ex_mem_stall = 1'b1; ex_req[4] = 1'b1; epc = 32'h0000_5000;
      ticks(11);
      ex_mem_stall = 1'b0;
      ticks(4);
      chk("stall_one_commit", 64'(commit_cnt - c0), 64'(1));

      // Reset in PEND
      c0 = commit_cnt;
      int_en = 16'h0080; pipe_clear = 1'b0; int_set[7] = 1'b1;
      ticks(2);
      chk("pre_rst_pending", 64'(pending), 64'(16'h0080));
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("post_rst_intr", 64'(intr), 64'(0));
      chk("post_rst_pending", 64'(pending), 64'(0));
      pipe_clear = 1'b1; int_en = '0;
      ticks(4);
      chk("rst_no_commit", 64'(commit_cnt - c0), 64'(0));

      // Randomized traffic
      for (int n = 0; n < 2000; n++) begin
         int_set      = NI'($urandom & $urandom & $urandom);
         int_clear    = NI'($urandom & $urandom & $urandom & $urandom);
         int_en       = NI'($urandom);
         mideleg      = NI'($urandom);
         medeleg      = NE'($urandom);
         case ($urandom_range(0, 9))
            0, 1, 2: curr_priv = 2'd0;
            3, 4, 5: curr_priv = 2'd1;
            6:       curr_priv = 2'd2;
            default: curr_priv = 2'd3;
         endcase
         mstatus_mie  = 1'($urandom_range(0, 1));
         mstatus_sie  = 1'($urandom_range(0, 1));
         pipe_clear   = ($urandom_range(0, 9) < 7);
         ex_mem_stall = ($urandom_range(0, 9) < 2);
         mret         = ($urandom_range(0, 9) == 0);
         sret         = ($urandom_range(0, 9) == 0);
         epc          = $urandom;
         if ($urandom_range(0, 9) == 0) begin
            ex_req[$urandom_range(0, NE - 1)] = 1'b1;
            if ($urandom_range(0, 1) == 1) ex_req[$urandom_range(0, NE - 1)] = 1'b1;
         end
         RST = ($urandom_range(0, 199) == 0);
         tick();
         RST = 1'b0;
      end

      // Drain
      int_en = '0; pipe_clear = 1'b1; ex_mem_stall = 1'b0;
      ticks(6);
      chk("queue_empty", 64'(exp_q.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
